// File: rtl/mesh_pkt_pkg.sv
// Packet layout, FSM state and classification helpers for the mesh terminal receiver.
package mesh_pkt_pkg;

    // Default mesh packet width; offsets below are derived from whatever width a user picks.
    localparam int unsigned PCKG_SZ_DEF = 41;
    localparam int unsigned HDR_W       = 17;

    function automatic int unsigned nxt_jmp_hi(input int unsigned psz);
        return psz - 1;
    endfunction

    function automatic int unsigned row_hi(input int unsigned psz);
        return psz - 9;
    endfunction

    function automatic int unsigned col_hi(input int unsigned psz);
        return psz - 13;
    endfunction

    function automatic int unsigned mode_bit(input int unsigned psz);
        return psz - 17;
    endfunction

    function automatic int unsigned payload_w(input int unsigned psz);
        return psz - HDR_W;
    endfunction

    typedef struct packed {
        logic [7:0]               nxt_jmp;
        logic [3:0]               row;
        logic [3:0]               col;
        logic                     mode;
        logic [PCKG_SZ_DEF-18:0]  payload;
    } mesh_pkt_t;

    typedef enum logic [1:0] {IDLE, POP, SETTLE} rx_state_e;

    typedef enum logic [1:0] {CLS_MATCH, CLS_BCST, CLS_MISROUTE} rx_class_e;

    // Broadcast wins over the range check since the broadcast ID lies outside the mesh.
    function automatic rx_class_e classify(
        input logic [3:0]  row,
        input logic [3:0]  col,
        input logic [3:0]  my_row,
        input logic [3:0]  my_col,
        input int unsigned rows,
        input int unsigned colums,
        input logic [7:0]  bdcst
    );
        if ({row, col} == bdcst) return CLS_BCST;
        if (32'(row) >= rows || 32'(col) >= colums) return CLS_MISROUTE;
        if (row == my_row && col == my_col) return CLS_MATCH;
        return CLS_MISROUTE;
    endfunction

endpackage

// File: rtl/mesh_term_rx_if.sv
// Router-side pop handshake plus consumer-side valid/ready channel.
// Optional rd_err signal exists only when MESH_RX_PASS_MISROUTE_EN is defined.
interface mesh_term_rx_if #(
    parameter int unsigned pckg_sz = 41
);
    logic               pndng;
    logic [pckg_sz-1:0] data_out;
    logic               popin;
    logic               rd_valid;
    logic [pckg_sz-18:0] rd_data;
    logic               rd_bcst;
    logic               rd_ready;
`ifdef MESH_RX_PASS_MISROUTE_EN
    logic               rd_err;

    modport slave (
        input  pndng, data_out, rd_ready,
        output popin, rd_valid, rd_data, rd_bcst, rd_err
    );
    modport master (
        output pndng, data_out, rd_ready,
        input  popin, rd_valid, rd_data, rd_bcst, rd_err
    );
`else
    modport slave (
        input  pndng, data_out, rd_ready,
        output popin, rd_valid, rd_data, rd_bcst
    );
    modport master (
        output pndng, data_out, rd_ready,
        input  popin, rd_valid, rd_data, rd_bcst
    );
`endif
endinterface

// File: rtl/mesh_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module mesh_rx_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_q, rd_q;
    logic             push_en, pop_en;

    // Occupancy flags and gated head.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_en  = pop && !empty;
        push_en = push && (!full || pop_en);
        head    = empty ? '0 : mem[rd_q[AW-1:0]];
    end

    // Storage array; contents need no reset because head is gated by empty.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_q[AW-1:0]] <= wdata;
    end

    // Read/write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_en) wr_q <= wr_q + 1'b1;
            if (pop_en)  rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/mesh_term_rx.sv
// Mesh terminal sink: pops the router output FIFO, filters by destination,
// buffers accepted payloads and counts accepted/misrouted packets.
// Optional macro MESH_RX_PASS_MISROUTE_EN forwards misroutes with an rd_err flag.
module mesh_term_rx
    import mesh_pkt_pkg::*;
#(
    parameter int unsigned pckg_sz    = 41,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLUMS     = 4,
    parameter logic [3:0]  MY_ROW     = 4'd1,
    parameter logic [3:0]  MY_COL     = 4'd1,
    parameter logic [7:0]  bdcst      = 8'hFF,
    parameter int unsigned fifo_depth = 8
) (
    input  logic          clk,
    input  logic          reset,
    mesh_term_rx_if.slave rx,
    output logic [15:0]   pkt_cnt,
    output logic [15:0]   err_cnt,
    output logic          misroute
);
    localparam int unsigned PayloadW = payload_w(pckg_sz);
    localparam int unsigned RowHi    = row_hi(pckg_sz);
    localparam int unsigned ColHi    = col_hi(pckg_sz);
    localparam int unsigned NjHi     = nxt_jmp_hi(pckg_sz);
    localparam int unsigned ModeBit  = mode_bit(pckg_sz);
`ifdef MESH_RX_PASS_MISROUTE_EN
    localparam int unsigned EntryW   = PayloadW + 2;
`else
    localparam int unsigned EntryW   = PayloadW + 1;
`endif

    rx_state_e          state_q, state_d;
    logic [pckg_sz-1:0] pkt_q;
    logic               capture, popin;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0]  fifo_wdata, fifo_head;
    rx_class_e          cls;
    logic               accept;
    logic               unused_hdr;

    // Header bits the terminal does not interpret.
    assign unused_hdr = ^{pkt_q[NjHi -: 8], pkt_q[ModeBit]};

    // Classify the registered packet and form the FIFO entry.
    always_comb begin
        cls    = classify(pkt_q[RowHi -: 4], pkt_q[ColHi -: 4], MY_ROW, MY_COL,
                          ROWS, COLUMS, bdcst);
        accept = (cls != CLS_MISROUTE);
        fifo_pop = !fifo_empty && rx.rd_ready;
`ifdef MESH_RX_PASS_MISROUTE_EN
        fifo_push  = (state_q == POP);
        fifo_wdata = {pkt_q[PayloadW-1:0], cls == CLS_BCST, !accept};
`else
        fifo_push  = (state_q == POP) && accept;
        fifo_wdata = {pkt_q[PayloadW-1:0], cls == CLS_BCST};
`endif
    end

    // Next-state and pop strobe; a same-cycle consumer read counts as free space.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        popin   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx.pndng && (!fifo_full || fifo_pop)) begin
                    capture = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                popin   = 1'b1;
                state_d = SETTLE;
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and packet capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) pkt_q <= rx.data_out;
        end
    end

    // Saturating counters and sticky misroute flag, updated in POP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            misroute <= 1'b0;
        end else if (state_q == POP) begin
            if (accept) begin
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                misroute <= 1'b1;
            end
        end
    end

    mesh_rx_fifo #(
        .width (EntryW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Consumer-side outputs.
    always_comb begin
        rx.popin    = popin;
        rx.rd_valid = !fifo_empty;
        rx.rd_data  = fifo_head[EntryW-1 -: PayloadW];
        rx.rd_bcst  = fifo_head[EntryW-PayloadW-1];
`ifdef MESH_RX_PASS_MISROUTE_EN
        rx.rd_err   = fifo_head[0];
`endif
    end
endmodule
